// File: rtl/nf10_10g_tx_arbiter_pkg.sv
// Shared constants for the 10G transmit arbiter: FSM encodings and the
// legal requester-count range.
package nf10_10g_arb_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int C_MIN_PORTS = 2;
  localparam int C_MAX_PORTS = 8;

  function automatic bit ports_legal(input int n);
    return (n >= C_MIN_PORTS) && (n <= C_MAX_PORTS);
  endfunction
endpackage

// File: rtl/nf10_10g_tx_arbiter_if.sv
// AXI4-Stream bundle, LANES streams side by side (LANES=1 for the single
// downstream link). Lane i of each field belongs to stream i.
interface nf10_10g_tx_arbiter_if #(
  parameter int LANES = 1,
  parameter int DW    = 64,
  parameter int UW    = 128
);
  logic [LANES-1:0][DW-1:0]   tdata;
  logic [LANES-1:0][DW/8-1:0] tstrb;
  logic [LANES-1:0][UW-1:0]   tuser;
  logic [LANES-1:0]           tvalid;
  logic [LANES-1:0]           tlast;
  logic [LANES-1:0]           tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_10g_tx_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after ptr_i, wrapping at N-1.
module nf10_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [2:0]   idx_o,
  output logic         found_o
);
  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign req2 = {req_i, req_i};
  assign rot  = N'(req2 >> ptr_i);

  always_comb begin : pick
    int j;
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        j = int'(ptr_i) + k;
        if (j >= N) j = j - N;
        idx_o   = 3'(j);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/nf10_10g_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one 10G transmit stream;
// never interleaves packets and counts forwarded packets per requester.
module nf10_10g_tx_arbiter
  import nf10_10g_arb_pkg::*;
#(
  parameter int C_NUM_PORTS   = 4,
  parameter int C_DATA_WIDTH  = 64,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_CNT_WIDTH   = 32
) (
  input  logic                                     axi_aclk,
  input  logic                                     axi_reset,
  nf10_10g_tx_arbiter_if.slave                     s_axis,
  nf10_10g_tx_arbiter_if.master                    m_axis,
  output logic [C_NUM_PORTS-1:0][C_CNT_WIDTH-1:0]  pkt_count,
  output logic [2:0]                               grant_id
);
  localparam int GW = $clog2(C_NUM_PORTS);

  if (!ports_legal(C_NUM_PORTS)) begin : g_bad_ports
    $error("C_NUM_PORTS out of range 2..8");
  end

  logic [0:0]   state_q, state_d;
  logic [2:0]   grant_q, grant_d;
  logic [2:0]   rr_ptr_q, rr_ptr_d;
  logic [C_NUM_PORTS-1:0][C_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [GW-1:0] gsel;
  logic [2:0]    pick_idx;
  logic          pick_found;
  logic          busy, xfer, done;

  nf10_rr_pick #(.N(C_NUM_PORTS)) u_pick (
    .req_i   (s_axis.tvalid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign gsel = grant_q[GW-1:0];
  assign busy = (state_q == ST_BUSY);

  // Payload always follows the grant; only valid/ready are gated by state.
  assign m_axis.tdata  = s_axis.tdata[gsel];
  assign m_axis.tstrb  = s_axis.tstrb[gsel];
  assign m_axis.tuser  = s_axis.tuser[gsel];
  assign m_axis.tlast  = s_axis.tlast[gsel];
  assign m_axis.tvalid = busy & s_axis.tvalid[gsel];

  always_comb begin
    s_axis.tready = '0;
    if (busy) s_axis.tready[gsel] = m_axis.tready[0];
  end

  assign xfer = m_axis.tvalid[0] & m_axis.tready[0];
  assign done = xfer & m_axis.tlast[0];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (!busy) begin
      if (pick_found) begin
        grant_d = pick_idx;
        state_d = ST_BUSY;
      end
    end else if (done) begin
      state_d     = ST_IDLE;
      rr_ptr_d    = (grant_q == 3'(C_NUM_PORTS - 1)) ? 3'd0 : grant_q + 3'd1;
      cnt_d[gsel] = cnt_q[gsel] + C_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pkt_count = cnt_q;
  assign grant_id  = grant_q;
endmodule

// File: doc/nf10_10g_tx_arbiter.md
# nf10_10g_tx_arbiter

Packet-granular round-robin arbiter that shares the transmit AXI4-Stream slave of one `nf10_10g_interface` instance between `C_NUM_PORTS` upstream requesters (e.g. the output queues and a CPU/DMA path). It sits directly in front of the 10G interface's `s_axis_*` port. It never interleaves beats of different packets. It keeps a per-requester count of forwarded packets for debug registers.

## Interface
Parameters:
- `C_NUM_PORTS`, default 4: number of requesters; legal range 2..8.
- `C_DATA_WIDTH`, default 64: tdata width; tstrb width is `C_DATA_WIDTH/8`.
- `C_TUSER_WIDTH`, default 128: tuser width.
- `C_CNT_WIDTH`, default 32: width of each packet counter.

Ports:
- `axi_aclk`  in  1  sole clock.
- `axi_reset`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  `C_NUM_PORTS*C_DATA_WIDTH`  requester data, port i in slice i.
- `s_axis_tstrb`  in  `C_NUM_PORTS*C_DATA_WIDTH/8`  byte strobes.
- `s_axis_tuser`  in  `C_NUM_PORTS*C_TUSER_WIDTH`  sideband, passed through unmodified.
- `s_axis_tvalid`  in  `C_NUM_PORTS`  per-requester valid.
- `s_axis_tlast`  in  `C_NUM_PORTS`  per-requester last.
- `s_axis_tready`  out  `C_NUM_PORTS`  per-requester ready.
- `m_axis_tdata`  out  `C_DATA_WIDTH`  to the interface's `s_axis_tdata`.
- `m_axis_tstrb`  out  `C_DATA_WIDTH/8`  strobes.
- `m_axis_tuser`  out  `C_TUSER_WIDTH`  sideband.
- `m_axis_tvalid`  out  1  valid.
- `m_axis_tready`  in  1  ready from the 10G interface.
- `m_axis_tlast`  out  1  last.
- `pkt_count`  out  `C_NUM_PORTS*C_CNT_WIDTH`  forwarded-packet count per requester.
- `grant_id`  out  3  currently or last granted requester index.

## Operation
- FSM with two states:
  - **IDLE:** if any `s_axis_tvalid[i]` is high, select the first i at or after `rr_ptr`, scanning upward with wrap at `C_NUM_PORTS-1`. Register `grant <= i` and go to **BUSY**. If no valid is high, stay in IDLE.
  - **BUSY:** the datapath multiplexes requester `grant` to `m_axis_*` combinationally.
    - `m_axis_tvalid = s_axis_tvalid[grant]`.
    - `s_axis_tready[grant] = m_axis_tready`. All other readies are 0.
    - A transfer is `m_axis_tvalid && m_axis_tready`.
    - On a transfer with `m_axis_tlast`: go to IDLE, set `rr_ptr <= (grant+1) mod C_NUM_PORTS`, and increment `pkt_count[grant]`.
- In IDLE: `m_axis_tvalid = 0` and all `s_axis_tready` are 0. `m_axis_tdata`, `tstrb`, `tuser` and `tlast` still mux `grant`; their values are don't-care.
- Counters wrap modulo 2^`C_CNT_WIDTH` without saturation.
- Requester valid dropping mid-packet is legal in BUSY. The arbiter waits and holds the grant indefinitely. There is no timeout.
- `grant_id` equals `grant`, zero-extended.

## Timing
- Reset values: FSM=IDLE, `grant`=0, `rr_ptr`=0, all `pkt_count`=0, `m_axis_tvalid`=0, `s_axis_tready`=0, `grant_id`=0.
- Reset asserted mid-packet forces IDLE immediately. The partial packet is truncated at the output with no tlast. Upstream and downstream must be reset together.
- Latency: a `tvalid` first seen in IDLE at cycle N produces `m_axis_tvalid` at cycle N+1. Data path has zero added latency in BUSY.
- One bubble cycle (IDLE) between consecutive packets. Maximum throughput is L/(L+1) beats/cycle for L-beat packets.
- Single-beat packet (tvalid and tlast together): one BUSY cycle if ready. The counter updates on the following edge.
- Simultaneous requests: the winner is decided only by `rr_ptr` order. A requester that just finished has lowest priority next round.
- `m_axis_tready` low in BUSY: the grant holds and all outputs follow the granted input unchanged. Upstream holds data per AXI-Stream rules.

## Structure
- Shared package/header `nf10_10g_arb_pkg`: FSM state encodings (`ST_IDLE`, `ST_BUSY`) and the `C_NUM_PORTS` legal range check constant.
- One sub-module `nf10_rr_pick`: combinational round-robin first-one-from-pointer selector. Inputs: request vector and pointer. Outputs: index and found flag.
- Counters and mux stay in the top.

## Test plan
- Single requester, port 2 sends a 3-beat packet, `m_axis_tready`=1: output appears at cycles N+1..N+3 with identical tdata/tstrb/tuser, and `pkt_count[2]`=1.
- All 4 ports continuously valid with 2-beat packets: grant order 0,1,2,3,0,1; exactly one idle cycle between packets; no interleaving.
- Port 1 drops tvalid for 5 cycles mid-packet while port 3 is valid: port 3 sees tready=0 throughout, and port 1's packet completes before port 3 is granted.
- `m_axis_tready` toggled randomly (50%) during a 10-beat packet: beats are delivered in order with no duplication or loss, and tready is visible only on the granted port.
- Preload `pkt_count[0]` near the top by forcing, e.g. `C_CNT_WIDTH`=4 with 16 packets on port 0: count wraps 15 to 0.
- Assert `axi_reset` during beat 2 of a 4-beat packet: next cycle `m_axis_tvalid`=0, all readies 0, counters 0, and after release port 0 wins the first arbitration.
